// File: rtl/dmem_store_bridge.sv
// Data-side store-buffer bridge for the pipelined core's M-stage memory port.
// Stores retire into a small FIFO without stalling. Loads are forwarded from
// the youngest matching buffered store. A load miss first drains the FIFO and
// then performs a single read over a req/ack handshake.
module dmem_store_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memwriteM,
  input  logic          memreadM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  output logic [DW-1:0] readdataM,
  output logic          stallM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] addr_q_r [DEPTH];
  logic [DW-1:0] data_q_r [DEPTH];
  logic [PW-1:0] head_r, tail_r, idx_s;
  logic [CW-1:0] count_r;
  logic          mem_req_r, mem_we_r, req_s, we_s, cap_s;
  logic [AW-1:0] mem_addr_r, addr_s;
  logic [DW-1:0] mem_wdata_r, wdata_s, held_r;
  logic          store_s, load_s, full_s, empty_s, enq_s, pop_s;
  logic          hit_s, stall_s;
  logic [DW-1:0] hit_data_s, rdata_s;

  assign store_s = memwriteM;                // a store wins when both strobes are high
  assign load_s  = memreadM & ~memwriteM;
  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CW{1'b0}});
  assign enq_s   = store_s & ~full_s;        // full blocks the store even if a pop lands now
  assign pop_s   = (state_r == WR) & mem_ack;

  // Forwarding search: walk from oldest to youngest so the youngest match wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = {DW{1'b0}};
    idx_s      = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PW'(k);
      if ((CW'(k) < count_r) && (addr_q_r[idx_s][AW-1:2] == aluoutM[AW-1:2])) begin
        hit_s      = 1'b1;
        hit_data_s = data_q_r[idx_s];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Core-facing stall and load data, resolved combinationally in the M stage.
  always_comb begin
    stall_s = 1'b0;
    rdata_s = {DW{1'b0}};
    if (store_s) begin
      stall_s = full_s;
    end else if (load_s) begin
      if (hit_s) begin
        rdata_s = hit_data_s;
      end else if (state_r == DONE) begin
        rdata_s = held_r;
      end else begin
        stall_s = 1'b1;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  // The freeze is released immediately while reset is held.
  assign stallM    = stall_s & rst;
  assign readdataM = rdata_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // Transaction FSM: next state and next values of the registered memory port.
  always_comb begin
    state_s = state_r;
    req_s   = mem_req_r;
    we_s    = mem_we_r;
    addr_s  = mem_addr_r;
    wdata_s = mem_wdata_r;
    cap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_s = WR;
          req_s   = 1'b1;
          we_s    = 1'b1;
          addr_s  = addr_q_r[head_r];
          wdata_s = data_q_r[head_r];
        end else if (load_s && !hit_s) begin
          state_s = RD;
          req_s   = 1'b1;
          we_s    = 1'b0;
          addr_s  = aluoutM;         // core is frozen, so this stays stable
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        if (mem_ack) begin
          state_s = IDLE;            // gives the mandatory idle cycle between writes
          req_s   = 1'b0;
          we_s    = 1'b0;
        end else begin
          state_s = WR;
        end
      end
      RD: begin
        if (mem_ack) begin
          state_s = DONE;
          req_s   = 1'b0;
          cap_s   = 1'b1;
        end else begin
          state_s = RD;
        end
      end
      DONE: begin
        state_s = IDLE;              // the load is consumed this cycle, never reissued
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // State and memory-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      state_r     <= state_s;
      mem_req_r   <= req_s;
      mem_we_r    <= we_s;
      mem_addr_r  <= addr_s;
      mem_wdata_r <= wdata_s;
    end
  end

  // Read data captured on the read acknowledge, presented during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r <= {DW{1'b0}};
    end else if (cap_s) begin
      held_r <= mem_rdata;
    end else begin
      held_r <= held_r;
    end
  end

  // Store FIFO: circular buffer with wrapping head/tail and an occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q_r[i] <= {AW{1'b0}};
        data_q_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (enq_s) begin
        addr_q_r[tail_r] <= aluoutM;
        data_q_r[tail_r] <= writedataM;
        tail_r           <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
